// File: rtl/mbist_pkg.sv
// Shared types and default widths for the MBIST response checker.
// Build option: MBIST_CMP_BITMAP_EN enables the failing-bit map.
package mbist_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 6;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] act;
  } fail_rec_t;

endpackage

// File: rtl/mbist_cmp_core.sv
// Registered unsigned magnitude compare with valid, plus a
// same-cycle mismatch flag for the counter and capture logic.
module mbist_cmp_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              mismatch,
  output logic              res_valid,
  output logic              gt,
  output logic              eq,
  output logic              lt
);

  assign mismatch = (a != b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      res_valid <= in_valid;
      if (in_valid) begin
        gt <= (a > b);
        eq <= (a == b);
        lt <= (a < b);
      end
    end
  end

endmodule

// File: rtl/mbist_resp_checker.sv
// MBIST response analyser: run FSM, saturating error count, first-fail
// capture; MBIST_CMP_BITMAP_EN adds the accumulated failing-bit map.
module mbist_resp_checker
  import mbist_pkg::*;
#(
  parameter int DATA_W    = mbist_pkg::DATA_W,
  parameter int ADDR_W    = mbist_pkg::ADDR_W,
  parameter int ERR_CNT_W = mbist_pkg::ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cmp_valid,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_t,
  input  logic [DATA_W-1:0]    ramout,
  input  logic                 test_end,
  output logic                 res_valid,
  output logic                 gt,
  output logic                 eq,
  output logic                 lt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_exp,
  output logic [DATA_W-1:0]    fail_act,
  output logic [DATA_W-1:0]    fail_bits
);

  // Local record sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] act;
  } rec_t;

  state_t state;
  rec_t   rec;
  logic   accept;
  logic   mismatch;

  assign accept = (state == RUN) && cmp_valid && !start;

  mbist_cmp_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .a        (data_t),
    .b        (ramout),
    .mismatch (mismatch),
    .res_valid(res_valid),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      rec     <= '0;
    end else if (start) begin
      state   <= RUN;
      busy    <= 1'b1;
      done    <= 1'b0;
      err_cnt <= '0;
      rec     <= '0;
    end else begin
      if (accept && mismatch) begin
        if (err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0)
          rec <= '{addr: addr, exp: data_t, act: ramout};
      end
      unique case (state)
        RUN: begin
          if (test_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass      = done && (err_cnt == '0);
  assign fail_addr = rec.addr;
  assign fail_exp  = rec.exp;
  assign fail_act  = rec.act;

`ifdef MBIST_CMP_BITMAP_EN
  logic [DATA_W-1:0] bits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bits_q <= '0;
    else if (start)
      bits_q <= '0;
    else if (accept)
      bits_q <= bits_q | (data_t ^ ramout);
  end

  assign fail_bits = bits_q;
`else
  assign fail_bits = '0;
`endif

endmodule
